// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and state encoding for the conv window scheduler
package conv_pkg;
  localparam int KSIZE = 3;
  localparam int TAPS = KSIZE * KSIZE;
  localparam int K_TOP = 0;
  localparam int K_MID = KSIZE;
  localparam int K_BOT = 2 * KSIZE;
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one frame row of pixels, old value read combinationally before the clocked write
module conv_line_buffer #(
  parameter int W = 8,
  parameter int DW = 8,
  localparam int AW = $clog2(W)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);
  logic [DW-1:0] mem [W];
  // store the accepted value at its column
  always_ff @(posedge clk_i) if (we_i) mem[addr_i] <= din_i;
  assign dout_o = mem[addr_i];
endmodule

// File: rtl/conv_window_sched.sv
// conv_window_sched: loads 3x3 weights, builds valid-only 3x3 windows from a raster pixel stream
module conv_window_sched import conv_pkg::*; #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               wgt_valid_i,
  input  logic [DW-1:0]      wgt_data_i,
  output logic               wgt_ready_o,
  input  logic               pix_valid_i,
  input  logic [DW-1:0]      pix_data_i,
  output logic               pix_ready_o,
  output logic [TAPS*DW-1:0] win_k_o,
  output logic [TAPS*DW-1:0] win_w_o,
  output logic               win_valid_o,
  output logic               conv_valid_o,
  output logic               busy_o,
  output logic               done_o
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  state_t state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [3:0] wcnt;
  logic [DW-1:0] tap [TAPS];
  logic [DW-1:0] wgt [TAPS];
  logic [DW-1:0] lb0_q, lb1_q;
  logic wgt_acc, pix_acc, col_last, last_pix;
  assign wgt_ready_o = state == LOAD_W;
  assign pix_ready_o = state == STREAM;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  assign wgt_acc = wgt_valid_i & wgt_ready_o;
  assign pix_acc = pix_valid_i & pix_ready_o;
  assign col_last = col == CW'(IMG_W - 1);
  assign last_pix = col_last && row == RW'(IMG_H - 1);
  conv_line_buffer #(.W(IMG_W), .DW(DW)) u_lb0 (
    .clk_i(clk_i), .we_i(pix_acc), .addr_i(col), .din_i(pix_data_i), .dout_o(lb0_q));
  conv_line_buffer #(.W(IMG_W), .DW(DW)) u_lb1 (
    .clk_i(clk_i), .we_i(pix_acc), .addr_i(col), .din_i(lb0_q), .dout_o(lb1_q));
  // state register
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;
  // next state: weights, then the frame, then one drain and one done cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_i ? LOAD_W : IDLE;
      LOAD_W:  state_n = wgt_acc && wcnt == 4'(TAPS - 1) ? STREAM : LOAD_W;
      STREAM:  state_n = pix_acc && last_pix ? DRAIN : STREAM;
      DRAIN:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // counters, weight store, tap shift and window/result valid pipeline
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col <= '0;
      row <= '0;
      wcnt <= '0;
      win_valid_o <= 1'b0;
      conv_valid_o <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        tap[i] <= '0;
        wgt[i] <= '0;
      end
    end else begin
      conv_valid_o <= win_valid_o;
      win_valid_o <= pix_acc && row >= RW'(2) && col >= CW'(2);
      if (wgt_acc) begin
        wgt[wcnt] <= wgt_data_i;
        wcnt <= wcnt == 4'(TAPS - 1) ? '0 : wcnt + 4'd1;
      end
      if (pix_acc) begin
        col <= col_last ? '0 : col + CW'(1);
        row <= col_last ? (row == RW'(IMG_H - 1) ? '0 : row + RW'(1)) : row;
        tap[K_TOP] <= tap[K_TOP+1];
        tap[K_TOP+1] <= tap[K_TOP+2];
        tap[K_TOP+2] <= lb1_q;
        tap[K_MID] <= tap[K_MID+1];
        tap[K_MID+1] <= tap[K_MID+2];
        tap[K_MID+2] <= lb0_q;
        tap[K_BOT] <= tap[K_BOT+1];
        tap[K_BOT+1] <= tap[K_BOT+2];
        tap[K_BOT+2] <= pix_data_i;
      end
    end
  end
  for (genvar g = 0; g < TAPS; g++) begin : g_pack
    assign win_k_o[g*DW +: DW] = tap[g];
    assign win_w_o[g*DW +: DW] = wgt[g];
  end
endmodule

// File: tb/tb_conv_window_sched.sv
// tb_conv_window_sched: table-driven frames on 4x4 and 8x8 schedulers checked against a window model
module tb_conv_window_sched;
  localparam int DW = 8;
  typedef struct {
    bit big;
    int wmode;
    int pmode;
    int stall;
    bit poke;
    int nwin;
    longint first;
    longint last;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, wgt_valid = 0, pix_valid = 0;
  logic [DW-1:0] wgt_data = '0, pix_data = '0;
  logic [9*DW-1:0] k0, w0, k1, w1, win_k, win_w;
  logic wr0, pr0, wv0, cv0, bz0, dn0, wr1, pr1, wv1, cv1, bz1, dn1;
  logic wr, pr, wv, cv, bz, dn;
  bit big = 0;
  int total = 0, passed = 0;
  int nacc = 0, kw = 0, pos = 0, nwin = 0, done_cnt = 0, cyc = 0, last_acc = 0, ww, r, c;
  bit pend_win = 0, prev_win = 0;
  logic signed [DW-1:0] fr [64];
  logic signed [DW-1:0] wm [9];
  logic signed [DW-1:0] tk, tw;
  longint s, first_sum, last_sum;
  vec_t tbl [6];

  always #5 clk = ~clk;

  conv_window_sched #(.IMG_W(4), .IMG_H(4), .DW(DW)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .wgt_valid_i(wgt_valid), .wgt_data_i(wgt_data),
    .wgt_ready_o(wr0), .pix_valid_i(pix_valid), .pix_data_i(pix_data), .pix_ready_o(pr0),
    .win_k_o(k0), .win_w_o(w0), .win_valid_o(wv0), .conv_valid_o(cv0), .busy_o(bz0), .done_o(dn0));
  conv_window_sched #(.IMG_W(8), .IMG_H(8), .DW(DW)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .wgt_valid_i(wgt_valid), .wgt_data_i(wgt_data),
    .wgt_ready_o(wr1), .pix_valid_i(pix_valid), .pix_data_i(pix_data), .pix_ready_o(pr1),
    .win_k_o(k1), .win_w_o(w1), .win_valid_o(wv1), .conv_valid_o(cv1), .busy_o(bz1), .done_o(dn1));

  assign win_k = big ? k1 : k0;
  assign win_w = big ? w1 : w0;
  assign wr = big ? wr1 : wr0;
  assign pr = big ? pr1 : pr0;
  assign wv = big ? wv1 : wv0;
  assign cv = big ? cv1 : cv0;
  assign bz = big ? bz1 : bz0;
  assign dn = big ? dn1 : dn0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_taps_nonzero"}, longint'(|win_k), 0);
    chk({tag, "_wgts_nonzero"}, longint'(|win_w), 0);
    chk({tag, "_outs"}, {wr, pr, wv, cv, bz, dn}, 0);
  endtask

  // Reference model: record accepted weights/pixels by frame position; a window is due
  // the cycle after any pixel at row>=2, col>=2, and its taps are the 3x3 block ending there.
  always @(negedge clk) begin
    ww = big ? 8 : 4;
    if (rst) begin
      nacc = 0;
      kw = 0;
      pend_win = 0;
      prev_win = 0;
    end else begin
      chk("win_valid", wv, pend_win);
      chk("conv_valid", cv, prev_win);
      chk("ready_overlap", wr & pr, 0);
      if (wv && pend_win) begin
        r = pos / ww;
        c = pos % ww;
        s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            tk = win_k[(i*3+j)*DW +: DW];
            tw = win_w[(i*3+j)*DW +: DW];
            chk($sformatf("tap%0d", i*3+j), tk, fr[(r-2+i)*ww + c-2+j]);
            chk($sformatf("wgt%0d", i*3+j), tw, wm[i*3+j]);
            s += tk * tw;
          end
        if (nwin == 0) first_sum = s;
        last_sum = s;
        nwin++;
      end
      if (dn) begin
        done_cnt++;
        chk("done_latency", cyc - last_acc, 2);
      end
      prev_win = pend_win;
      pend_win = 0;
      if (start && !bz) begin
        nacc = 0;
        kw = 0;
        nwin = 0;
        done_cnt = 0;
      end
      if (wgt_valid && wr && kw < 9) begin
        wm[kw] = wgt_data;
        kw++;
      end
      if (pix_valid && pr && nacc < 64) begin
        fr[nacc] = pix_data;
        pos = nacc;
        pend_win = nacc / ww >= 2 && nacc % ww >= 2;
        nacc++;
        last_acc = cyc;
      end
    end
    cyc++;
  end

  task automatic run_frame(input int wmode, input int pmode, input int stall, input bit poke, input int stop_after);
    int guard, npix;
    bit acc;
    npix = stop_after > 0 ? stop_after : (big ? 64 : 16);
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 9; k++) begin
      wgt_data = wmode == 0 ? DW'(1) : wmode == 1 ? DW'(k) : DW'($urandom);
      guard = 0;
      do begin
        wgt_valid = $urandom_range(0, 99) >= stall;
        acc = wgt_valid && wr;
        step();
        guard++;
      end while (!acc && guard < 200);
      if (!acc) chk("wgt_accept_timeout", 0, 1);
    end
    wgt_valid = 0;
    for (int n = 0; n < npix; n++) begin
      pix_data = pmode == 0 ? DW'(n) : pmode == 1 ? DW'(1) : DW'($urandom);
      start = poke && n == 5;
      guard = 0;
      do begin
        pix_valid = $urandom_range(0, 99) >= stall;
        acc = pix_valid && pr;
        step();
        start = 0;
        guard++;
      end while (!acc && guard < 200);
      if (!acc) chk("pix_accept_timeout", 0, 1);
    end
    pix_valid = 0;
    if (stop_after == 0) begin
      guard = 0;
      while (done_cnt == 0 && guard < 20) begin
        step();
        guard++;
      end
      repeat (3) step();
    end
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 0, 0, 4, 45, 90};
    tbl[1] = '{0, 1, 1, 0, 0, 4, 36, 36};
    tbl[2] = '{0, 0, 0, 50, 0, 4, 45, 90};
    tbl[3] = '{0, 1, 0, 0, 1, 4, 258, 438};
    tbl[4] = '{0, 2, 2, 30, 0, 4, -1, -1};
    tbl[5] = '{1, 0, 0, 0, 0, 36, 81, 486};
    rst = 1;
    repeat (3) step();
    check_idle("reset");
    rst = 0;
    step();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        run_frame(0, 0, 0, 0, 7);
        rst = 1;
        step();
        check_idle("mid_reset");
        rst = 0;
        step();
        run_frame(0, 0, 0, 0, 0);
        chk("after_reset_windows", nwin, 4);
        chk("after_reset_done", done_cnt, 1);
        chk("after_reset_first", first_sum, 45);
        chk("after_reset_last", last_sum, 90);
      end
      if (tbl[i].big != big) begin
        rst = 1;
        big = tbl[i].big;
        step();
        step();
        check_idle("reset_big");
        rst = 0;
        step();
      end
      run_frame(tbl[i].wmode, tbl[i].pmode, tbl[i].stall, tbl[i].poke, 0);
      chk($sformatf("row%0d_windows", i), nwin, tbl[i].nwin);
      chk($sformatf("row%0d_done", i), done_cnt, 1);
      chk($sformatf("row%0d_idle_after", i), bz, 0);
      if (tbl[i].first >= 0) begin
        chk($sformatf("row%0d_first_sum", i), first_sum, tbl[i].first);
        chk($sformatf("row%0d_last_sum", i), last_sum, tbl[i].last);
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
